cmp_result_filter: RTL
======================

// Module: cmp_result_filter
// PURPOSE
//  Downstream stage of the 4-bit magnitude comparator. Samples its less/equal/greater
//  flags on a valid strobe and commits a result only after STABLE_CNT consecutive
//  identical samples (debounce). Reports the committed result as one-hot, pulses on
//  every committed change, counts changes, and flags illegal (non-one-hot) flag sets.
// PARAMETERS
//  STABLE_CNT  4  consecutive identical valid samples required to commit (>=1)
//  CNT_W       8  width of change counter
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  in_valid     in   1      less/equal/greater are sampled this cycle
//  less         in   1      comparator A<B
//  equal        in   1      comparator A==B
//  greater      in   1      comparator A>B
//  clr          in   1      synchronous clear of chg_count and err
//  res_less     out  1      committed result A<B
//  res_equal    out  1      committed result A==B
//  res_greater  out  1      committed result A>B
//  res_valid    out  1      a result has been committed since reset
//  chg_pulse    out  1      one-cycle pulse on each commit that changes the result
//  chg_count    out  CNT_W  commits that changed an existing result; saturating
//  err          out  1      sticky: illegal flag combination seen
// BEHAVIOUR
//  - Reset (rst_n low, async): FSM=INIT; all outputs 0; cand=NONE; run=0.
//  - FSM states: INIT (nothing committed), LT, EQ, GT. The res_* outputs are a one-hot
//    decode of the state; INIT decodes to 000. res_valid=0 only in INIT.
//  - Legal sample: in_valid=1 and exactly one of {less,equal,greater} is set.
//    Code == cand: run = min(run+1, STABLE_CNT). Otherwise: cand=code, run=1.
//  - Commit: at the rising edge where a legal sample makes run reach STABLE_CNT, and
//    cand != state, the state becomes cand at that edge. All outputs are registered.
//    Latency: the result is visible the cycle after the STABLE_CNT-th matching sample.
//  - Once run is saturated, further matching samples cause no new commit.
//  - chg_pulse=1 for exactly the cycle after each commit, including INIT->first
//    result.
//  - chg_count +1 on each commit out of LT/EQ/GT; not on INIT->first. Holds at
//    2^CNT_W-1.
//  - Illegal sample: in_valid=1 with 0, 2 or 3 flags set. Sets err=1. cand=NONE, run=0.
//    State is unchanged and no pulse is generated.
//  - in_valid=0: flags ignored; cand/run/state hold. Gaps do not break a run.
//  - clr=1: chg_count=0 and err=0 next edge. A clear wins over a same-cycle increment
//    or error set. Does not affect state/cand/run/chg_pulse.
//  - STABLE_CNT=1: every legal sample that differs from the state commits immediately.
//  - Reset asserted mid-run or mid-pulse: everything returns to reset values at once.
// TESTING
//  1 reset, then 4 valid equal samples -> res_equal=1, res_valid=1 after 4th edge; chg_pulse
//    1 cycle; chg_count=0.
//  2 from EQ: greater x3, less x1, greater x4 -> GT committed only after the last 4; chg_count=1.
//  3 valid greater samples with in_valid=0 gaps between -> commits after 4th valid sample.
//  4 from LT: in_valid with less=1,equal=1 -> err=1, state LT held; run restarts; clr -> err=0.
//  5 force 300 alternating commits (CNT_W=8) -> chg_count saturates at 255; clr with commit -> 0.
//  6 rst_n low mid-run and during chg_pulse -> all outputs 0 immediately, INIT on release.

Source files
------------

// File: rtl/cmp_result_filter_if.sv
// Purpose : Bundles the sample strobe, comparator flags, clear and all result
//           outputs of cmp_result_filter into one interface.
// Modports: master - drives in_valid/less/equal/greater/clr, observes results
//           slave  - the filter itself: consumes inputs, drives results
interface cmp_result_filter_if #(
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic             less;
    logic             equal;
    logic             greater;
    logic             clr;
    logic             res_less;
    logic             res_equal;
    logic             res_greater;
    logic             res_valid;
    logic             chg_pulse;
    logic [CNT_W-1:0] chg_count;
    logic             err;

    modport master (
        output in_valid, less, equal, greater, clr,
        input  res_less, res_equal, res_greater, res_valid,
        input  chg_pulse, chg_count, err
    );

    modport slave (
        input  in_valid, less, equal, greater, clr,
        output res_less, res_equal, res_greater, res_valid,
        output chg_pulse, chg_count, err
    );
endinterface

// File: rtl/cmp_result_filter.sv
// Purpose : Debounce stage behind a 4-bit magnitude comparator. A result is
//           committed only after STABLE_CNT consecutive identical legal samples;
//           the committed result is reported one-hot, every change is pulsed
//           and counted (saturating), and non-one-hot flag sets raise a sticky
//           error.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset
//           bus   - cmp_result_filter_if.slave
//                   in : in_valid, less, equal, greater, clr
//                   out: res_less, res_equal, res_greater, res_valid,
//                        chg_pulse, chg_count[CNT_W-1:0], err
module cmp_result_filter #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cmp_result_filter_if.slave   bus
);
    localparam int               RUN_W   = $clog2(STABLE_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CNT);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {ST_INIT, ST_LT, ST_EQ, ST_GT} state_t;
    // Same encoding as state_t so a candidate maps directly onto a state.
    typedef enum logic [1:0] {CODE_NONE, CODE_LT, CODE_EQ, CODE_GT} code_t;

    state_t           r_state;
    state_t           w_state_n;
    code_t            r_cand;
    code_t            w_cand_n;
    code_t            w_code;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_n;
    logic             w_legal;
    logic             w_illegal;
    logic             w_reach;
    logic             w_commit;

    logic             r_res_less;
    logic             r_res_equal;
    logic             r_res_greater;
    logic             r_res_valid;
    logic             r_chg_pulse;
    logic [CNT_W-1:0] r_chg_count;
    logic             r_err;

    // Flag decode: anything other than exactly one flag is NONE.
    always_comb begin
        w_code = CODE_NONE;
        unique case ({bus.less, bus.equal, bus.greater})
            3'b100:  w_code = CODE_LT;
            3'b010:  w_code = CODE_EQ;
            3'b001:  w_code = CODE_GT;
            default: w_code = CODE_NONE;
        endcase
    end

    assign w_legal   = bus.in_valid && (w_code != CODE_NONE);
    assign w_illegal = bus.in_valid && (w_code == CODE_NONE);

    // Candidate/run tracking. w_reach fires only on the sample that brings the
    // run up to STABLE_CNT; a run already saturated never re-triggers.
    always_comb begin
        w_cand_n = r_cand;
        w_run_n  = r_run;
        w_reach  = 1'b0;
        if (w_legal) begin
            if (w_code == r_cand) begin
                if (r_run != RUN_MAX) begin
                    w_run_n = r_run + RUN_ONE;
                    w_reach = (w_run_n == RUN_MAX);
                end
            end else begin
                w_cand_n = w_code;
                w_run_n  = RUN_ONE;
                w_reach  = (RUN_ONE == RUN_MAX);
            end
        end else if (w_illegal) begin
            w_cand_n = CODE_NONE;
            w_run_n  = '0;
        end
    end

    assign w_commit = w_reach && (2'(w_cand_n) != 2'(r_state));

    // Next-state logic of the result FSM.
    always_comb begin
        w_state_n = r_state;
        if (w_commit) begin
            w_state_n = state_t'(2'(w_cand_n));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand <= CODE_NONE;
            r_run  <= '0;
        end else begin
            r_cand <= w_cand_n;
            r_run  <= w_run_n;
        end
    end

    // Result flags are registered from the next state so they change in the
    // same cycle as r_state, without a combinational decode on the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_less    <= 1'b0;
            r_res_equal   <= 1'b0;
            r_res_greater <= 1'b0;
            r_res_valid   <= 1'b0;
            r_chg_pulse   <= 1'b0;
        end else begin
            r_res_less    <= (w_state_n == ST_LT);
            r_res_equal   <= (w_state_n == ST_EQ);
            r_res_greater <= (w_state_n == ST_GT);
            r_res_valid   <= (w_state_n != ST_INIT);
            r_chg_pulse   <= w_commit;
        end
    end

    // Only changes of an existing result are counted; clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chg_count <= '0;
            r_err       <= 1'b0;
        end else if (bus.clr) begin
            r_chg_count <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_commit && (r_state != ST_INIT) && (r_chg_count != CNT_MAX)) begin
                r_chg_count <= r_chg_count + CNT_ONE;
            end
            if (w_illegal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.res_less    = r_res_less;
    assign bus.res_equal   = r_res_equal;
    assign bus.res_greater = r_res_greater;
    assign bus.res_valid   = r_res_valid;
    assign bus.chg_pulse   = r_chg_pulse;
    assign bus.chg_count   = r_chg_count;
    assign bus.err         = r_err;
endmodule
